// File: rtl/delay_trainer_pkg.sv
// Shared constants and state encoding for the lane skew trainer.
// Lane geometry matches the 4-lane x 16-bit delay stage it configures.
package delay_trainer_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 16;
    localparam int DLY_W  = 4;

    localparam logic [DLY_W-1:0] DLY_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_STEP,
        ST_DONE
    } trainer_state_t;

    function automatic logic [LANE_W-1:0] lane_word(
        input logic [LANES*LANE_W-1:0] bus,
        input int                      k
    );
        return bus[k*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/delay_trainer_lane.sv
// Per-lane pass/fail tracking for one delay step, plus the lock flag and
// the delay value frozen when the lane first passes.
module delay_lane_check
    import delay_trainer_pkg::*;
(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              restart,
    input  logic              clear,
    input  logic              cmp,
    input  logic [LANE_W-1:0] word,
    input  logic [LANE_W-1:0] pattern,
    input  logic              step,
    input  logic [DLY_W-1:0]  d,
    output logic              pass,
    output logic              locked,
    output logic [DLY_W-1:0]  dly
);

    logic hit;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hit    <= 1'b0;
            locked <= 1'b0;
            dly    <= '0;
        end else begin
            if (clear) begin
                hit <= 1'b1;
            end else if (cmp && (word != pattern)) begin
                hit <= 1'b0;
            end

            // Only the first passing delay is kept; later steps leave it alone.
            if (restart) begin
                locked <= 1'b0;
                dly    <= '0;
            end else if (step && hit && !locked) begin
                locked <= 1'b1;
                dly    <= d;
            end
        end
    end

    assign pass = hit && !locked;

endmodule

// File: rtl/delay_trainer.sv
// Skew-training controller: sweeps the four lane delays of the delay stage and
// locks each lane at the smallest delay where the pattern lands on the compare cycle.
//
// state  | meaning
// IDLE   | no run since reset, waiting for start
// SETTLE | delay line refilling after a cfg change, compares ignored
// CHECK  | counting compare events against the pattern
// STEP   | lock passing lanes, advance d or finish
// DONE   | run finished, found delays held until next start
module delay_trainer
    import delay_trainer_pkg::*;
#(
    parameter int REF_LAT = 8,
    parameter int MARKS   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic                    mark,
    input  logic [LANE_W-1:0]       pattern,
    input  logic [LANES*LANE_W-1:0] din,
    output logic [LANES*DLY_W-1:0]  cfg,
    output logic [LANES-1:0]        locked,
    output logic                    busy,
    output logic                    done
);

    localparam int               SETTLE_CYC  = REF_LAT + 16;
    localparam logic [5:0]       SETTLE_LOAD = 6'(SETTLE_CYC - 1);
    localparam logic [3:0]       EV_LAST     = 4'(MARKS - 1);
    localparam logic [15:0]      TMO_LOAD    = 16'(TIMEOUT - 1);

    trainer_state_t             state;
    logic [REF_LAT:0]           mark_sr;
    logic [LANES*LANE_W-1:0]    din_q;
    logic [5:0]                 settle_cnt;
    logic [3:0]                 ev_cnt;
    logic [15:0]                tmo_cnt;
    logic [DLY_W-1:0]           d;
    logic                       timed_out;

    logic                       cmp_stb;
    logic                       hit_clr;
    logic                       step_ok;
    logic                       lane_restart;
    logic                       finish;
    logic [LANES-1:0]           pass;
    logic [LANES-1:0]           lock_now;
    logic [LANES-1:0]           lock_all;
    logic [DLY_W-1:0]           dly [LANES];

    // The extra stage beyond REF_LAT lines the strobe up with the registered din.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mark_sr <= '0;
            din_q   <= '0;
        end else begin
            mark_sr <= {mark_sr[REF_LAT-1:0], mark};
            din_q   <= din;
        end
    end

    assign cmp_stb      = mark_sr[REF_LAT] && (state == ST_CHECK);
    assign hit_clr      = (state == ST_SETTLE) && (settle_cnt == '0);
    assign step_ok      = (state == ST_STEP) && !timed_out;
    assign lane_restart = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign lock_now     = pass & {LANES{step_ok}};
    assign lock_all     = locked | lock_now;
    assign finish       = (&lock_all) || (d == DLY_MAX);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        delay_lane_check u_lane (
            .aclk    (aclk),
            .aresetn (aresetn),
            .restart (lane_restart),
            .clear   (hit_clr),
            .cmp     (cmp_stb),
            .word    (lane_word(din_q, g)),
            .pattern (pattern),
            .step    (step_ok),
            .d       (d),
            .pass    (pass[g]),
            .locked  (locked[g]),
            .dly     (dly[g])
        );
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            cfg        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            d          <= '0;
            settle_cnt <= '0;
            ev_cnt     <= '0;
            tmo_cnt    <= '0;
            timed_out  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_SETTLE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        d          <= '0;
                        cfg        <= '0;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state     <= ST_CHECK;
                        ev_cnt    <= '0;
                        tmo_cnt   <= TMO_LOAD;
                        timed_out <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                ST_CHECK: begin
                    tmo_cnt <= tmo_cnt - 1'b1;
                    if (cmp_stb) begin
                        ev_cnt <= ev_cnt + 1'b1;
                    end
                    // A final event landing on the timeout cycle still counts as a full check.
                    if (cmp_stb && (ev_cnt == EV_LAST)) begin
                        state     <= ST_STEP;
                        timed_out <= 1'b0;
                    end else if (tmo_cnt == '0) begin
                        state     <= ST_STEP;
                        timed_out <= 1'b1;
                    end
                end

                ST_STEP: begin
                    for (int k = 0; k < LANES; k++) begin
                        if (locked[k]) begin
                            cfg[k*DLY_W +: DLY_W] <= dly[k];
                        end else if (lock_now[k]) begin
                            cfg[k*DLY_W +: DLY_W] <= d;
                        end else if (finish) begin
                            cfg[k*DLY_W +: DLY_W] <= '0;
                        end else begin
                            cfg[k*DLY_W +: DLY_W] <= d + 1'b1;
                        end
                    end
                    if (finish) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state      <= ST_SETTLE;
                        d          <= d + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_trainer.sv
// Directed bench for delay_trainer: a behavioural skewed delay stage feeds din
// from the trainer's own cfg, and each step checks hand-computed outputs.
module tb_delay_trainer;

    localparam int REF_LAT = 8;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start;
    logic        mark;
    logic [15:0] pattern;
    logic [63:0] din;
    logic [15:0] cfg;
    logic [3:0]  locked;
    logic        busy;
    logic        done;

    logic        start_to;
    logic        mark_to;
    logic [63:0] din_to;
    logic [15:0] cfg_to;
    logic [3:0]  locked_to;
    logic        busy_to;
    logic        done_to;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int ideal [4];
    bit lane_en [4];
    int partial_lane;
    bit mark_en;

    always #5 aclk = ~aclk;

    delay_trainer #(.REF_LAT(REF_LAT), .MARKS(4), .TIMEOUT(65535)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .start   (start),
        .mark    (mark),
        .pattern (pattern),
        .din     (din),
        .cfg     (cfg),
        .locked  (locked),
        .busy    (busy),
        .done    (done)
    );

    delay_trainer #(.REF_LAT(REF_LAT), .MARKS(4), .TIMEOUT(100)) dut_to (
        .aclk    (aclk),
        .aresetn (aresetn),
        .start   (start_to),
        .mark    (mark_to),
        .pattern (pattern),
        .din     (din_to),
        .cfg     (cfg_to),
        .locked  (locked_to),
        .busy    (busy_to),
        .done    (done_to)
    );

    always @(posedge aclk) cyc <= cyc + 1;

    // Skewed delay stage: lane k's word lands on the compare cycle only when cfg[k] == ideal[k].
    always @(negedge aclk) begin
        mark = mark_en && (cyc % 64 == 0);
        for (int k = 0; k < 4; k++) begin
            int  c;
            int  x;
            bit  hit;
            c   = int'(cfg[4*k +: 4]);
            x   = cyc - c - REF_LAT + ideal[k];
            hit = lane_en[k] && (x >= 0) && (x % 64 == 0);
            if (k == partial_lane) begin
                x   = x - 1;
                hit = hit || ((x >= 0) && (x % 64 == 0) && ((x / 64) % 4 != 0));
            end
            din[16*k +: 16] = hit ? pattern : ~pattern;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit to_inst);
        @(negedge aclk);
        if (to_inst) start_to = 1'b1; else start = 1'b1;
        @(posedge aclk);
        #1;
        start    = 1'b0;
        start_to = 1'b0;
    endtask

    task automatic wait_done(input bit to_inst, input int limit, input string tag, output int n);
        n = 0;
        while (!(to_inst ? done_to : done) && n < limit) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk(tag, 64'(n < limit), 64'h1);
    endtask

    task automatic wait_lane(input int lane, input logic [3:0] val, input int limit, input string tag);
        int n = 0;
        while (cfg[4*lane +: 4] !== val && n < limit) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk(tag, 64'(n < limit), 64'h1);
    endtask

    initial begin
        int n;
        aresetn      = 1'b1;
        start        = 1'b0;
        start_to     = 1'b0;
        mark_to      = 1'b0;
        din_to       = '0;
        pattern      = 16'hA5C3;
        mark_en      = 1'b1;
        partial_lane = -1;
        ideal        = '{0, 3, 7, 12};
        lane_en      = '{1, 1, 1, 1};
        #3 aresetn = 1'b0;
        #1;
        chk("rst_cfg",    64'(cfg),    64'h0);
        chk("rst_locked", 64'(locked), 64'h0);
        chk("rst_busy",   64'(busy),   64'h0);
        chk("rst_done",   64'(done),   64'h0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;

        // Skews 0/3/7/12
        pulse_start(1'b0);
        chk("t1_busy_after_start", 64'(busy), 64'h1);
        chk("t1_cfg_after_start",  64'(cfg),  64'h0);
        wait_lane(1, 4'd2, 2000, "t1_reach_d2");
        chk("t1_locked_d2", 64'(locked), 64'h1);
        chk("t1_cfg_d2",    64'(cfg),    64'h2220);
        pulse_start(1'b0);
        chk("busy_start_locked", 64'(locked), 64'h1);
        chk("busy_start_cfg",    64'(cfg),    64'h2220);
        chk("busy_start_busy",   64'(busy),   64'h1);
        wait_done(1'b0, 8000, "t1_done_wait", n);
        chk("t1_cfg",    64'(cfg),    64'hC730);
        chk("t1_locked", 64'(locked), 64'hF);
        chk("t1_busy",   64'(busy),   64'h0);

        // Retrain after done: lane 2 dead, others skew 2
        ideal      = '{2, 2, 2, 2};
        lane_en[2] = 1'b0;
        pulse_start(1'b0);
        chk("rerun_done",   64'(done),   64'h0);
        chk("rerun_locked", 64'(locked), 64'h0);
        chk("rerun_busy",   64'(busy),   64'h1);
        chk("rerun_cfg",    64'(cfg),    64'h0);
        wait_done(1'b0, 8000, "t2_done_wait", n);
        chk("t2_locked", 64'(locked), 64'hB);
        chk("t2_cfg",    64'(cfg),    64'h2022);

        // No marks, TIMEOUT = 100: 16 timed-out steps
        pulse_start(1'b1);
        chk("to_busy", 64'(busy_to), 64'h1);
        wait_done(1'b1, 3000, "to_done_wait", n);
        chk("to_run_length", 64'((n >= 16*(REF_LAT+16+100)) && (n <= 16*(REF_LAT+16+100+2))), 64'h1);
        chk("to_locked", 64'(locked_to), 64'h0);
        chk("to_cfg",    64'(cfg_to),    64'h0);
        chk("to_busy_end", 64'(busy_to), 64'h0);

        // Reset mid-sweep at d = 5, then a fresh run from d = 0
        ideal   = '{0, 6, 9, 9};
        lane_en = '{1, 1, 1, 1};
        pulse_start(1'b0);
        wait_lane(3, 4'd5, 3000, "rst_reach_d5");
        chk("rst_mid_locked_pre", 64'(locked), 64'h1);
        chk("rst_mid_cfg_pre",    64'(cfg),    64'h5550);
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_cfg",    64'(cfg),    64'h0);
        chk("rst_mid_locked", 64'(locked), 64'h0);
        chk("rst_mid_busy",   64'(busy),   64'h0);
        chk("rst_mid_done",   64'(done),   64'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        pulse_start(1'b0);
        chk("restart_cfg",  64'(cfg),  64'h0);
        chk("restart_busy", 64'(busy), 64'h1);
        wait_done(1'b0, 8000, "restart_done_wait", n);
        chk("restart_cfg_final",    64'(cfg),    64'h9960);
        chk("restart_locked_final", 64'(locked), 64'hF);

        // Lane 0 matches 3 of 4 events at d = 4, all at d = 5
        ideal        = '{5, 1, 2, 3};
        partial_lane = 0;
        pulse_start(1'b0);
        wait_lane(0, 4'd5, 3000, "partial_reach_d5");
        chk("partial_locked_d5", 64'(locked), 64'hE);
        wait_done(1'b0, 8000, "partial_done_wait", n);
        chk("partial_cfg",    64'(cfg),    64'h3215);
        chk("partial_locked", 64'(locked), 64'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/delay_trainer.md
# delay_trainer

Automatic skew-training controller for the 4-lane × 16-bit `delay` stage. It watches the stage's 64-bit output during a training burst and sweeps the four 4-bit lane delays. For each lane it finds the smallest delay at which a known pattern word appears in a fixed cycle after a reference mark. It drives the stage's 16-bit `cfg` bus directly, and sits beside the delay stage between the ADC deserializer and the data path.

## Interface
- `REF_LAT`, default 8: cycles from `mark` to the compare cycle; legal range 1..31.
- `MARKS`, default 4: consecutive compare events a lane must match to pass a delay value; legal range 1..15.
- `TIMEOUT`, default 65535: maximum cycles spent in CHECK per delay step; legal range 1..65535.
- `aclk` in 1: clock; all logic is rising-edge.
- `aresetn` in 1: reset; asynchronous assert, active-low.
- `start` in 1: single-cycle training request.
- `mark` in 1: reference strobe; high on the cycle the training word enters the earliest lane.
- `pattern` in 16: expected lane word; held stable while `busy`.
- `din` in 64: delay stage `dout`; lane k is bits [16k+15:16k].
- `cfg` out 16: delay stage `cfg`; lane k delay is bits [4k+3:4k].
- `locked` out 4: per-lane "delay found" flags.
- `busy` out 1: training in progress.
- `done` out 1: training finished; level, held until the next accepted `start`.

## Operation
- States: IDLE, SETTLE, CHECK, STEP, DONE.
- IDLE → SETTLE on `start`:
  - clear `locked` and `done`, set `busy`;
  - sweep value d := 0;
  - `cfg` := 0 on all lanes.
- SETTLE: wait exactly REF_LAT+16 cycles so the delay line refills and pending compares drain. No compare results are used. Then → CHECK, clear per-lane hit flags to 1 and the event counter to 0.
- Compare event:
  - `mark` feeds a REF_LAT-deep shift register.
  - When its output is 1, each lane word of registered `din` is compared with `pattern`.
  - Any mismatch clears that lane's hit flag.
  - Overlapping marks are all honoured.
- CHECK: count compare events. When the count reaches MARKS, or TIMEOUT cycles elapse, → STEP. On timeout, all unlocked lanes are treated as failing this d.
- STEP:
  - each unlocked lane whose hit flag is 1 sets `locked[k]` and freezes `cfg[k]` at d;
  - if all lanes are locked or d = 15 → DONE;
  - otherwise d := d+1, unlocked lanes get `cfg` = d, → SETTLE.
- DONE:
  - `busy` = 0, `done` = 1;
  - unlocked lanes get `cfg` = 0;
  - locked lanes keep their found value;
  - on `start` → re-enter the IDLE→SETTLE transition, i.e. a fresh training run.
- `start` while `busy` is ignored. `mark` outside CHECK only advances the shift register.
- `aresetn` low at any time, including mid-sweep: `cfg` = 0, `locked` = 0, `busy` = 0, `done` = 0, state IDLE, shift register and counters cleared.

## Timing
- `start` sampled at edge t: `busy` = 1 and `cfg` = 0 from t+1; the first compare is not earlier than t+1+REF_LAT+16.
- `din` is registered once inside the block. A `mark` sampled at edge t is compared against `din` sampled at edge t+REF_LAT.
- `cfg`, `locked`, `busy` and `done` are registered outputs with no combinational paths from inputs.
- A lane with a successful d: `locked[k]` and `cfg[k]` update on the edge leaving STEP.
- `done` rises on the same edge as the final STEP→DONE transition; `busy` falls on that edge.
- Worst-case run: 16 × (REF_LAT+16+TIMEOUT+2) cycles.

## Structure
- Package `delay_trainer_pkg`:
  - constants LANES = 4, LANE_W = 16, DLY_W = 4;
  - state enum `trainer_state_t`.
- Sub-module `delay_lane_check`, one per lane:
  - holds the hit flag, lock flag and frozen delay;
  - inputs: compare strobe, lane word, pattern, clear, step, d.
- Top level holds the FSM, mark shift register, settle/event/timeout counters and `cfg` assembly.

## Test plan
- Lanes skewed by 0/3/7/12 cycles, ideal `cfg` 0/3/7/12, `pattern` 16'hA5C3, `mark` every 64 cycles → `done` with `cfg` = 16'hC730 and `locked` = 4'hF.
- Lane 2 never produces `pattern`, other lanes skew 2 → after the d = 15 step `locked` = 4'hB and `cfg` = 16'h2022.
- `mark` held low, TIMEOUT = 100 → 16 timed-out steps, `done` with `locked` = 0 and `cfg` = 0.
- `aresetn` pulsed low while d = 5 → all outputs 0 on the same cycle; a later `start` restarts the sweep at d = 0.
- `start` pulsed while `busy` → no effect. `start` after `done` → `done` and `locked` clear next cycle and retraining runs.
- Lane matching at d = 4 on only 3 of MARKS = 4 events and fully at d = 5 → `cfg` lane = 5.
